// File: rtl/fpu_pkg.sv
// Shared FPU constants: IEEE-754 single field layout, divider sizing and FSM state type.
// Defining FP_DIV_ROUND_EN adds one quotient bit for round-to-nearest-even.
package fpu_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    localparam int unsigned SIGN_POS = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned SIG_W    = MAN_W + 1;
    localparam int unsigned REM_W    = SIG_W + 1;

`ifdef FP_DIV_ROUND_EN
    localparam int unsigned DIV_STEPS = 26;
`else
    localparam int unsigned DIV_STEPS = 25;
`endif
    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ITER = ST_ITER,
        NORM = ST_NORM,
        DONE = ST_DONE
    } fp_div_state_t;

endpackage

// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for fp_divider; the divider is the slave side.
interface fp_divider_if;

    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        exception;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a_operand, b_operand, in_valid, out_ready,
        input  in_ready, result, exception, out_valid
    );

    modport slave (
        input  a_operand, b_operand, in_valid, out_ready,
        output in_ready, result, exception, out_valid
    );

endinterface

// File: rtl/fp_div_iter.sv
// Restoring radix-2 divider datapath: remainder/quotient/divisor registers and
// one compare-subtract-shift step per asserted step.
module fp_div_iter
    import fpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [SIG_W-1:0]     dividend,
    input  logic [SIG_W-1:0]     divisor,
    output logic [DIV_STEPS-1:0] q,
    output logic [REM_W-1:0]     r
);

    logic [REM_W-1:0]     r_q, r_d;
    logic [DIV_STEPS-1:0] q_q, q_d;
    logic [SIG_W-1:0]     d_q, d_d;
    logic [SIG_W-1:0]     diff;
    logic                 ge;

    // Remainder stays below the divisor after each step, so the top bit of diff is always zero.
    always_comb begin
        ge   = (r_q >= {1'b0, d_q});
        diff = ge ? SIG_W'(r_q - {1'b0, d_q}) : r_q[SIG_W-1:0];
        r_d  = r_q;
        q_d  = q_q;
        d_d  = d_q;
        if (load) begin
            r_d = {1'b0, dividend};
            q_d = '0;
            d_d = divisor;
        end else if (step) begin
            r_d = {diff, 1'b0};
            q_d = {q_q[DIV_STEPS-2:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

    assign q = q_q;
    assign r = r_q;

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider: FSM, special-case decode, normalization.
// FP_DIV_ROUND_EN enables round-to-nearest-even; otherwise the quotient is truncated.
module fp_divider
    import fpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fp_divider_if.slave  dif
);

    fp_div_state_t       state_q, state_d;
    logic                sign_q, sign_d;
    logic signed [9:0]   exp_q, exp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         result_q, result_d;
    logic                exc_q, exc_d;

    logic [7:0]          a_exp, b_exp;
    logic                sign_in, load, step;
    logic [DIV_STEPS-1:0] quo;
    logic [REM_W-1:0]    rem;

    logic signed [9:0]   exp_n;
    logic [MAN_W-1:0]    mant_n;
    logic [31:0]         norm_result;
    logic                norm_exc;

    assign a_exp   = dif.a_operand[EXP_MSB:EXP_LSB];
    assign b_exp   = dif.b_operand[EXP_MSB:EXP_LSB];
    assign sign_in = dif.a_operand[SIGN_POS] ^ dif.b_operand[SIGN_POS];

    assign load = (state_q == IDLE) && dif.in_valid &&
                  (a_exp != EXP_MAX) && (b_exp != EXP_MAX) &&
                  (b_exp != 8'd0) && (a_exp != 8'd0);
    assign step = (state_q == ITER);

    fp_div_iter u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .dividend ({1'b1, dif.a_operand[MAN_W-1:0]}),
        .divisor  ({1'b1, dif.b_operand[MAN_W-1:0]}),
        .q        (quo),
        .r        (rem)
    );

`ifdef FP_DIV_ROUND_EN
    logic              guard, sticky, round_up;
    logic [MAN_W:0]    mant_sum;
    logic [MAN_W-1:0]  mant_t;

    // Guard is the first dropped quotient bit; everything below it, plus the remainder, is sticky.
    always_comb begin
        exp_n = exp_q;
        if (quo[DIV_STEPS-1]) begin
            mant_t = quo[DIV_STEPS-2:2];
            guard  = quo[1];
            sticky = quo[0] | (rem != '0);
        end else begin
            mant_t = quo[DIV_STEPS-3:1];
            guard  = quo[0];
            sticky = (rem != '0);
            exp_n  = exp_q - 10'sd1;
        end
        round_up = guard & (sticky | mant_t[0]);
        mant_sum = {1'b0, mant_t} + {{MAN_W{1'b0}}, round_up};
        mant_n   = mant_sum[MAN_W-1:0];
        if (mant_sum[MAN_W]) begin
            exp_n = exp_n + 10'sd1;
        end
    end
`else
    logic unused_rem;
    assign unused_rem = ^rem;

    always_comb begin
        exp_n = exp_q;
        if (quo[DIV_STEPS-1]) begin
            mant_n = quo[DIV_STEPS-2:1];
        end else begin
            mant_n = quo[DIV_STEPS-3:0];
            exp_n  = exp_q - 10'sd1;
        end
    end
`endif

    always_comb begin
        norm_exc    = 1'b0;
        norm_result = {sign_q, exp_n[7:0], mant_n};
        if (exp_n >= $signed({2'b00, EXP_MAX})) begin
            norm_exc    = 1'b1;
            norm_result = '0;
        end else if (exp_n <= 10'sd0) begin
            norm_result = {sign_q, 31'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE: begin
                if (dif.in_valid) begin
                    sign_d = sign_in;
                    exp_d  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                           + $signed(10'(EXP_BIAS));
                    cnt_d  = '0;
                    if ((a_exp == EXP_MAX) || (b_exp == EXP_MAX) || (b_exp == 8'd0)) begin
                        exc_d    = 1'b1;
                        result_d = '0;
                        state_d  = DONE;
                    end else if (a_exp == 8'd0) begin
                        exc_d    = 1'b0;
                        result_d = {sign_in, 31'b0};
                        state_d  = DONE;
                    end else begin
                        state_d  = ITER;
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                result_d = norm_result;
                exc_d    = norm_exc;
                state_d  = DONE;
            end
            DONE: begin
                if (dif.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign dif.in_ready  = (state_q == IDLE);
    assign dif.out_valid = (state_q == DONE);
    assign dif.result    = result_q;
    assign dif.exception = exc_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: directed vectors, latency, backpressure and mid-run reset.
module tb_fp_divider;

`ifdef FP_DIV_ROUND_EN
    localparam int unsigned NLAT = 28;
    localparam logic [31:0] Q_THIRD = 32'h3EAAAAAB;
`else
    localparam int unsigned NLAT = 27;
    localparam logic [31:0] Q_THIRD = 32'h3EAAAAAA;
`endif

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        cur;
    logic        have_cur = 1'b0;
    logic        prev_valid = 1'b0;

    fp_divider_if dif ();

    fp_divider dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Monitor: pop an expectation when out_valid rises, then hold it against every valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                have_cur   = 1'b0;
            end else begin
                if (dif.out_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL spurious_out_valid: got result %h with no pending operation", dif.result);
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1'b1;
                        check("latency", cyc, cur.due);
                    end
                end
                if (dif.out_valid && have_cur) begin
                    check("result", dif.result, cur.res);
                    check("exception", {31'b0, dif.exception}, {31'b0, cur.exc});
                end
                prev_valid = dif.out_valid;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic e, input int unsigned lat);
        int unsigned n;
        exp_t x;
        n = 0;
        @(negedge clk);
        dif.a_operand = a;
        dif.b_operand = b;
        dif.in_valid  = 1'b1;
        while (!dif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dif.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            x.res = r;
            x.exc = e;
            x.due = cyc + lat;
            sb.push_back(x);
        end
        @(negedge clk);
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int unsigned n;
        n = 0;
        while (!dif.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", {31'b0, dif.out_valid}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        int unsigned n;
        dif.a_operand = '0;
        dif.b_operand = '0;
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  {31'b0, dif.in_ready},  32'd1);
        check("reset_out_valid", {31'b0, dif.out_valid}, 32'd0);
        check("reset_result",    dif.result,             32'd0);
        check("reset_exception", {31'b0, dif.exception}, 32'd0);

        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, NLAT);  // 6/2
        issue(32'h3F800000, 32'h40400000, Q_THIRD,      1'b0, NLAT);  // 1/3
        issue(32'h3F800000, 32'h00000000, 32'h00000000, 1'b1, 1);     // div by zero
        issue(32'h7F800000, 32'h3F800000, 32'h00000000, 1'b1, 1);     // Inf operand
        issue(32'h3F800000, 32'h7FC00000, 32'h00000000, 1'b1, 1);     // NaN divisor
        issue(32'h00000000, 32'h7F800000, 32'h00000000, 1'b1, 1);     // exp-255 beats zero dividend
        issue(32'h7F000000, 32'h3F000000, 32'h00000000, 1'b1, NLAT);  // overflow
        issue(32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1);     // -0 / 2
        issue(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, NLAT);  // -6/2
        issue(32'h40000000, 32'h40000000, 32'h3F800000, 1'b0, NLAT);  // 2/2
        issue(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, NLAT);  // underflow

        // Backpressure: hold out_ready low for five valid cycles, poke in_valid meanwhile.
        n = 0;
        while (!dif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        dif.out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, NLAT);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", {31'b0, dif.in_ready}, 32'd0);
            dif.a_operand = 32'h3F800000;
            dif.b_operand = 32'h3F800000;
            dif.in_valid  = 1'b1;
            @(negedge clk);
        end
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready",  {31'b0, dif.in_ready},  32'd1);
        check("bp_release_out_valid", {31'b0, dif.out_valid}, 32'd0);

        // Reset in the middle of ITER, then a fresh operation.
        @(negedge clk);
        dif.a_operand = 32'h40C00000;
        dif.b_operand = 32'h40000000;
        dif.in_valid  = 1'b1;
        check("abort_accept_in_ready", {31'b0, dif.in_ready}, 32'd1);
        t0 = cyc;
        @(negedge clk);
        dif.in_valid = 1'b0;
        while (cyc < t0 + 5) @(negedge clk);
        check("abort_busy_in_ready", {31'b0, dif.in_ready}, 32'd0);
        while (cyc < t0 + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready",  {31'b0, dif.in_ready},  32'd1);
        check("abort_out_valid", {31'b0, dif.out_valid}, 32'd0);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, NLAT);

        n = 0;
        while ((sb.size() != 0 || dif.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("final_out_valid", {31'b0, dif.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
